clock_time_counter: RTL and testbench
=====================================

# clock_time_counter

Timekeeping core of the digital clock. Divides the system clock down to a 1 Hz tick and keeps 24-hour time as six BCD digits (HH:MM:SS), with a small mode FSM for setting hours, minutes and seconds from two pre-debounced key pulses. Its six BCD outputs feed the eight-digit multiplexed 7-segment display controller directly downstream.

## Interface
Parameters:
- TICK_DIV, default 50_000_000: i_clk cycles per second; legal range 2 and above. The prescaler width is ceil(log2(TICK_DIV)).

Ports:
- i_clk  in  1  system clock; all state changes on the rising edge.
- r_rst_n  in  1  asynchronous, active-low reset.
- i_en  in  1  count enable; when low in RUN, the prescaler and time are frozen.
- i_key_mode  in  1  single-cycle pulse, already debounced; advances the mode FSM.
- i_key_inc  in  1  single-cycle pulse, already debounced; increments the field selected in a set mode.
- o_hour_h  out  4  hours tens, BCD 0-2.
- o_hour_l  out  4  hours units, BCD 0-9.
- o_minute_h  out  4  minutes tens, BCD 0-5.
- o_minute_l  out  4  minutes units, BCD 0-9.
- o_second_h  out  4  seconds tens, BCD 0-5.
- o_second_l  out  4  seconds units, BCD 0-9.
- o_sec_tick  out  1  one-cycle pulse on every running second advance.
- o_mode  out  2  current mode: 0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_SEC.

## Operation
- Reset: all digits are 0 (00:00:00), prescaler is 0, o_mode is 0 (RUN), o_sec_tick is 0.
- Prescaler: counts 0..TICK_DIV-1. It only counts in RUN with i_en high.
- Mode FSM: each i_key_mode pulse steps RUN → SET_HOUR → SET_MIN → SET_SEC → RUN.
- In any SET state:
  - the prescaler is held at 0 and no ticks occur;
  - i_en is ignored.
- RUN advance: carry chain second_l → second_h → minute_l → minute_h → hour.
  - second_l 9→0 with carry.
  - second_h 5→0 with carry when second_l wraps.
  - Minutes follow the same rule as seconds.
  - Hours: hour_l 9→0 increments hour_h; 23 followed by a carry wraps to 00.
  - 23:59:59 advances to 00:00:00.
- SET increment: i_key_inc increments only the selected field, with no carry into other fields.
  - Hours wrap 23→00.
  - Minutes and seconds wrap 59→00.
  - BCD format is kept, e.g. 09→10 and 19→20.
- i_key_inc in RUN is ignored.
- Simultaneous i_key_mode and i_key_inc in the same cycle: the mode change wins and the increment is dropped.
- Output digits are never outside their BCD ranges; no illegal state is reachable.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- Tick edge: at the rising edge where prescaler == TICK_DIV-1 (RUN, i_en=1), three things happen together:
  - the prescaler loads 0;
  - the time registers take the advanced value;
  - o_sec_tick goes to 1.
  - At the next edge o_sec_tick returns to 0, unless another tick occurs at that edge, which is only possible when TICK_DIV=1 and that value is illegal.
- Tick period is exactly TICK_DIV cycles. The first tick after reset comes TICK_DIV edges after reset is released.
- i_en low: the prescaler holds its value. Counting resumes from that value, so no partial second is lost or restarted.
- Mode change: o_mode updates on the edge that samples i_key_mode.
- Entering SET_HOUR clears the prescaler on the same edge.
- Leaving SET_SEC for RUN: the prescaler starts from 0, so the first tick comes TICK_DIV cycles later.
- SET increment: the field updates on the edge that samples i_key_inc, one-cycle latency.
- Reset asserted mid-operation (any mode, mid-prescale) immediately forces every register to its reset value, asynchronously.

## Test plan
Simulate with TICK_DIV=4.
- Reset release, i_en=1, 40 cycles: o_sec_tick pulses every 4 cycles starting at cycle 4; digits read 00:00:10 after cycle 40; o_mode=0.
- Seconds preset to 59 via SET_SEC, minutes to 59, hours to 23, then return to RUN: the next tick gives 00:00:00 with one o_sec_tick pulse. Checking that 09:59:59 advances to 10:00:00 covers the hour_l carry.
- i_en low for 10 cycles mid-prescale, at prescaler=2: no tick and digits unchanged. After i_en rises, the tick arrives 2 cycles later.
- Mode cycling: four i_key_mode pulses give o_mode 1, 2, 3, 0. In SET_MIN from 58, three i_key_inc pulses give 59, 00, 01, with hours and seconds unchanged and no o_sec_tick. In SET_HOUR from 19, one inc gives 20.
- Same-cycle i_key_mode and i_key_inc in SET_HOUR: o_mode becomes 2 and hours are unchanged. An i_key_inc in RUN leaves all digits unchanged.
- r_rst_n pulsed low asynchronously (between clock edges) while in SET_MIN showing 12:34:56: all digits, o_mode and o_sec_tick read 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/clock_time_counter.sv
// 24-hour BCD timekeeper: divides i_clk to a 1 Hz tick and keeps HH:MM:SS,
// with a RUN/SET_HOUR/SET_MIN/SET_SEC mode FSM driven by two key pulses.
module clock_time_counter #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       i_clk,
  input  logic       r_rst_n,
  input  logic       i_en,
  input  logic       i_key_mode,
  input  logic       i_key_inc,
  output logic [3:0] o_hour_h,
  output logic [3:0] o_hour_l,
  output logic [3:0] o_minute_h,
  output logic [3:0] o_minute_l,
  output logic [3:0] o_second_h,
  output logic [3:0] o_second_l,
  output logic       o_sec_tick,
  output logic [1:0] o_mode
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2,
    MODE_SET_SEC  = 2'd3
  } mode_t;

  mode_t         mode_reg;
  logic [PW-1:0] prescaler_reg;
  logic          sec_tick_reg;
  logic [3:0]    hour_h_reg, hour_l_reg;
  logic [3:0]    minute_h_reg, minute_l_reg;
  logic [3:0]    second_h_reg, second_l_reg;

  logic       tick;
  logic       set_inc;
  logic       sec_wrap, min_wrap;
  logic [7:0] sec_next, min_next, hour_next;

  // Two-digit 00..59 increment, wrapping 59 -> 00.
  function automatic logic [7:0] inc_sexa(input logic [3:0] h, input logic [3:0] l);
    logic [7:0] r;
    if (l == 4'd9) begin
      r = (h == 4'd5) ? 8'h00 : {h + 4'd1, 4'd0};
    end else begin
      r = {h, l + 4'd1};
    end
    return r;
  endfunction

  // Two-digit 00..23 increment, wrapping 23 -> 00.
  function automatic logic [7:0] inc_hour(input logic [3:0] h, input logic [3:0] l);
    logic [7:0] r;
    if (h == 4'd2 && l == 4'd3) begin
      r = 8'h00;
    end else if (l == 4'd9) begin
      r = {h + 4'd1, 4'd0};
    end else begin
      r = {h, l + 4'd1};
    end
    return r;
  endfunction

  always_comb begin
    tick      = (mode_reg == MODE_RUN) && i_en && (prescaler_reg == PRESC_MAX);
    // A mode key in the same cycle takes priority and drops the increment.
    set_inc   = i_key_inc && !i_key_mode && (mode_reg != MODE_RUN);
    sec_wrap  = (second_h_reg == 4'd5) && (second_l_reg == 4'd9);
    min_wrap  = (minute_h_reg == 4'd5) && (minute_l_reg == 4'd9);
    sec_next  = inc_sexa(second_h_reg, second_l_reg);
    min_next  = inc_sexa(minute_h_reg, minute_l_reg);
    hour_next = inc_hour(hour_h_reg, hour_l_reg);
  end

  always_ff @(posedge i_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      mode_reg      <= MODE_RUN;
      prescaler_reg <= '0;
      sec_tick_reg  <= 1'b0;
      hour_h_reg    <= 4'd0;
      hour_l_reg    <= 4'd0;
      minute_h_reg  <= 4'd0;
      minute_l_reg  <= 4'd0;
      second_h_reg  <= 4'd0;
      second_l_reg  <= 4'd0;
    end else begin
      sec_tick_reg <= tick;

      // Set modes (and the edge entering SET_HOUR) hold the prescaler at zero.
      if (mode_reg != MODE_RUN || i_key_mode) begin
        prescaler_reg <= '0;
      end else if (i_en) begin
        prescaler_reg <= tick ? '0 : prescaler_reg + PW'(1);
      end

      if (i_key_mode) begin
        case (mode_reg)
          MODE_RUN:      mode_reg <= MODE_SET_HOUR;
          MODE_SET_HOUR: mode_reg <= MODE_SET_MIN;
          MODE_SET_MIN:  mode_reg <= MODE_SET_SEC;
          default:       mode_reg <= MODE_RUN;
        endcase
      end

      if (tick) begin
        {second_h_reg, second_l_reg} <= sec_next;
        if (sec_wrap) begin
          {minute_h_reg, minute_l_reg} <= min_next;
          if (min_wrap) begin
            {hour_h_reg, hour_l_reg} <= hour_next;
          end
        end
      end else if (set_inc) begin
        case (mode_reg)
          MODE_SET_HOUR: {hour_h_reg, hour_l_reg}     <= hour_next;
          MODE_SET_MIN:  {minute_h_reg, minute_l_reg} <= min_next;
          MODE_SET_SEC:  {second_h_reg, second_l_reg} <= sec_next;
          default: ;
        endcase
      end
    end
  end

  assign o_hour_h   = hour_h_reg;
  assign o_hour_l   = hour_l_reg;
  assign o_minute_h = minute_h_reg;
  assign o_minute_l = minute_l_reg;
  assign o_second_h = second_h_reg;
  assign o_second_l = second_l_reg;
  assign o_sec_tick = sec_tick_reg;
  assign o_mode     = mode_reg;

endmodule

// File: tb/tb_clock_time_counter.sv
// Directed bench for clock_time_counter with TICK_DIV=4; expected values are
// hand-computed and time is compared as a packed 24-bit BCD HHMMSS word.
module tb_clock_time_counter;

  logic       i_clk = 1'b0;
  logic       r_rst_n = 1'b0;
  logic       i_en = 1'b0;
  logic       i_key_mode = 1'b0;
  logic       i_key_inc = 1'b0;
  logic [3:0] o_hour_h, o_hour_l, o_minute_h, o_minute_l, o_second_h, o_second_l;
  logic       o_sec_tick;
  logic [1:0] o_mode;

  int checks_total = 0;
  int checks_passed = 0;

  clock_time_counter #(.TICK_DIV(4)) dut (
    .i_clk      (i_clk),
    .r_rst_n    (r_rst_n),
    .i_en       (i_en),
    .i_key_mode (i_key_mode),
    .i_key_inc  (i_key_inc),
    .o_hour_h   (o_hour_h),
    .o_hour_l   (o_hour_l),
    .o_minute_h (o_minute_h),
    .o_minute_l (o_minute_l),
    .o_second_h (o_second_h),
    .o_second_l (o_second_l),
    .o_sec_tick (o_sec_tick),
    .o_mode     (o_mode)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks_total++;
    if (observed === expected) begin
      checks_passed++;
    end else begin
      $display("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] time_now();
    return {8'h00, o_hour_h, o_hour_l, o_minute_h, o_minute_l, o_second_h, o_second_l};
  endfunction

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic pulse_mode();
    i_key_mode = 1'b1;
    step();
    i_key_mode = 1'b0;
  endtask

  task automatic pulse_inc(input int n);
    for (int i = 0; i < n; i++) begin
      i_key_inc = 1'b1;
      step();
      i_key_inc = 1'b0;
    end
  endtask

  initial begin
    step();
    step();
    check("reset_time", time_now(), 32'h000000);
    check("reset_mode", {30'd0, o_mode}, 32'd0);
    check("reset_tick", {31'd0, o_sec_tick}, 32'd0);

    // Free run: tick on every 4th edge after release, 10 seconds in 40 cycles.
    r_rst_n = 1'b1;
    i_en = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      step();
      check($sformatf("run_tick_c%0d", c), {31'd0, o_sec_tick}, {31'd0, (c % 4 == 0)});
    end
    $display("run 40 cycles: time=%06h mode=%0d", time_now(), o_mode);
    check("run_time_40", time_now(), 32'h000010);
    check("run_mode", {30'd0, o_mode}, 32'd0);

    // Enable low at prescaler=2 for 10 cycles, then tick 2 cycles after resume.
    step();
    step();
    i_en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      check("hold_no_tick", {31'd0, o_sec_tick}, 32'd0);
    end
    check("hold_time", time_now(), 32'h000010);
    i_en = 1'b1;
    step();
    check("resume_tick1", {31'd0, o_sec_tick}, 32'd0);
    step();
    check("resume_tick2", {31'd0, o_sec_tick}, 32'd1);
    check("resume_time", time_now(), 32'h000011);
    $display("enable hold/resume: time=%06h", time_now());

    // Mode cycling 1,2,3,0.
    pulse_mode(); check("mode_1", {30'd0, o_mode}, 32'd1);
    pulse_mode(); check("mode_2", {30'd0, o_mode}, 32'd2);
    pulse_mode(); check("mode_3", {30'd0, o_mode}, 32'd3);
    pulse_mode(); check("mode_0", {30'd0, o_mode}, 32'd0);
    $display("mode cycle done: mode=%0d time=%06h", o_mode, time_now());

    // Hours: 00 -> 19 -> 20 -> 23, then mode+inc together drops the inc.
    pulse_mode();
    pulse_inc(19); check("set_hour_19", time_now(), 32'h190011);
    pulse_inc(1);  check("set_hour_20", time_now(), 32'h200011);
    pulse_inc(3);  check("set_hour_23", time_now(), 32'h230011);
    i_key_mode = 1'b1;
    i_key_inc = 1'b1;
    step();
    i_key_mode = 1'b0;
    i_key_inc = 1'b0;
    check("simul_mode", {30'd0, o_mode}, 32'd2);
    check("simul_hours", time_now(), 32'h230011);
    $display("simultaneous keys: mode=%0d time=%06h", o_mode, time_now());

    // Minutes: 00 -> 58 -> 59 -> 00 -> 01, no tick in set modes.
    pulse_inc(58); check("set_min_58", time_now(), 32'h235811);
    pulse_inc(1);  check("set_min_59", time_now(), 32'h235911);
    pulse_inc(1);  check("set_min_00", time_now(), 32'h230011);
    pulse_inc(1);  check("set_min_01", time_now(), 32'h230111);
    check("set_no_tick", {31'd0, o_sec_tick}, 32'd0);
    pulse_inc(58); check("set_min_59b", time_now(), 32'h235911);
    pulse_mode();
    pulse_inc(48); check("set_sec_59", time_now(), 32'h235959);
    pulse_mode();
    check("back_to_run", {30'd0, o_mode}, 32'd0);

    // 23:59:59 -> 00:00:00, first tick 4 cycles after leaving SET_SEC.
    for (int c = 1; c <= 3; c++) begin
      step();
      check("midnight_wait", {31'd0, o_sec_tick}, 32'd0);
    end
    step();
    check("midnight_tick", {31'd0, o_sec_tick}, 32'd1);
    check("midnight_time", time_now(), 32'h000000);
    $display("midnight rollover: time=%06h", time_now());

    // 09:59:59 -> 10:00:00 covers the hour_l carry.
    pulse_mode(); pulse_inc(9);
    pulse_mode(); pulse_inc(59);
    pulse_mode(); pulse_inc(59);
    pulse_mode();
    check("preset_095959", time_now(), 32'h095959);
    step(); step(); step(); step();
    check("hour_carry_tick", {31'd0, o_sec_tick}, 32'd1);
    check("hour_carry_time", time_now(), 32'h100000);
    $display("hour carry: time=%06h", time_now());

    // Increment key in RUN is ignored.
    pulse_inc(1);
    check("inc_in_run", time_now(), 32'h100000);

    // Async reset while in SET_MIN showing 12:34:56.
    pulse_mode(); pulse_inc(2);
    pulse_mode(); pulse_inc(34);
    pulse_mode(); pulse_inc(56);
    pulse_mode(); pulse_mode(); pulse_mode();
    check("pre_reset_time", time_now(), 32'h123456);
    check("pre_reset_mode", {30'd0, o_mode}, 32'd2);
    #2;
    r_rst_n = 1'b0;
    #1;
    check("async_rst_time", time_now(), 32'h000000);
    check("async_rst_mode", {30'd0, o_mode}, 32'd0);
    check("async_rst_tick", {31'd0, o_sec_tick}, 32'd0);
    $display("async reset: time=%06h mode=%0d", time_now(), o_mode);
    step();
    r_rst_n = 1'b1;
    step();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
